// File: rtl/spi_slave_sync.sv
// SPI responder, fully in the clk domain: oversampled SCLK/SS/MOSI, all four modes,
// LSB-first frames, one-entry TX and RX buffers with valid/ready handshakes.
module spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              overrun,
  output logic              underrun,
  output logic              state_dbg
);

  // Handshakes: a word moves on any clk edge where valid & ready are both high;
  // valid must not depend on ready, and data is held stable while valid waits.

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;

  logic [DATA_W-1:0] shift_q, tx_buf;
  logic              tx_full, miso_q, cpol_q, cpha_q;
  logic [CNT_W-1:0]  cnt_q;

  logic active, ss_fall, ss_rise, sclk_edge, lead, trail;
  logic start, sample, shift_e, done, load, accept;
  logic [DATA_W-1:0] rx_word;

  // SS synchronises to its idle (high) level so reset never fakes a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign active    = (state_q == ACTIVE);
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_edge = sclk_s ^ sclk_d;
  assign lead      = sclk_edge & (sclk_d == cpol_q);
  assign trail     = sclk_edge & (sclk_s == cpol_q);

  assign start   = (state_q == IDLE) & ss_fall;
  assign sample  = active & ~ss_rise & (cpha_q ? trail : lead);
  assign shift_e = active & ~ss_rise & (cpha_q ? lead : trail);
  assign done    = sample & (cnt_q == CNT_W'(DATA_W - 1));
  assign load    = start | done;
  assign accept  = din_valid & ~tx_full;
  assign rx_word = {mosi_s, shift_q[DATA_W-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      miso_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      cnt_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      if (accept) begin
        tx_buf  <= din;
        tx_full <= 1'b1;
      end
      if (start) begin
        cpol_q <= mode[1];
        cpha_q <= mode[0];
        cnt_q  <= '0;
      end
      if (sample) begin
        shift_q <= rx_word;
        cnt_q   <= done ? '0 : cnt_q + CNT_W'(1);
      end
      if (done) begin
        dout       <= rx_word;
        dout_valid <= 1'b1;
        overrun    <= dout_valid & ~dout_ready;
      end
      // Frame start and back-to-back completion both take the buffered word.
      if (load) begin
        shift_q  <= tx_full ? tx_buf : '0;
        underrun <= ~tx_full;
        if (tx_full) tx_full <= 1'b0;
      end
      if (start)        miso_q <= tx_full ? tx_buf[0] : 1'b0;
      else if (shift_e) miso_q <= shift_q[0];
      if (active && ss_rise) cnt_q <= '0;
    end
  end

  assign din_ready = ~tx_full;
  assign busy      = active;
  assign state_dbg = state_q;
  assign MISO      = active ? miso_q : 1'bz;

endmodule
